// File: rtl/alu_seq_pkg.sv
// Shared encodings for the ALU sequencer: RV32I opcodes, operand-select codes,
// ALU op codes and the sequencer state enum.
package alu_seq_pkg;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;

   localparam logic [1:0] RS_RS1 = 2'b00;
   localparam logic [1:0] RS_PC  = 2'b10;

   localparam logic [1:0] B_RS2  = 2'b00;
   localparam logic [1:0] B_IMM  = 2'b01;
   localparam logic [1:0] B_FOUR = 2'b10;

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b0001;
   localparam logic [3:0] ALU_PASS = 4'b1111;

   typedef enum logic [2:0] {
      S_IDLE,
      S_EXEC,
      S_CMP,
      S_LINK,
      S_TGT,
      S_DONE
   } state_e;

endpackage

// File: rtl/alu_seq_ctrl_brcond.sv
// Branch condition decode: funct3 plus ALU compare flags -> taken / illegal.
module alu_seq_ctrl_brcond (
   input  logic [2:0] funct3,
   input  logic       alu_zero,
   input  logic       alu_lt,
   input  logic       alu_ltu,
   output logic       taken,
   output logic       illegal
);

   always_comb begin
      taken   = 1'b0;
      illegal = 1'b0;
      case (funct3)
         3'b000:  taken = alu_zero;
         3'b001:  taken = ~alu_zero;
         3'b100:  taken = alu_lt;
         3'b101:  taken = ~alu_lt;
         3'b110:  taken = alu_ltu;
         3'b111:  taken = ~alu_ltu;
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Multi-cycle sequencer steering the shared ALU through compare/link/target phases.
// Optional macro ALU_SEQ_MISALIGN_EN: flag targets with bit1 set as errors.
module alu_seq_ctrl
   import alu_seq_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [6:0]      opcode,
   input  logic [2:0]      funct3,
   input  logic            alu_zero,
   input  logic            alu_lt,
   input  logic            alu_ltu,
   input  logic [XLEN-1:0] alu_res,
   output logic [1:0]      rs_sel,
   output logic [1:0]      b_sel,
   output logic [3:0]      alu_op,
   output logic            rd_we,
   output logic            pc_we,
   output logic [XLEN-1:0] tgt_out,
   output logic            resp_valid,
   output logic            resp_taken,
   output logic            resp_err
);

   state_e          state_q, state_d;
   logic [6:0]      op_q, op_d;
   logic [2:0]      f3_q, f3_d;
   logic [XLEN-1:0] tgt_q, tgt_d;
   logic            taken_q, taken_d;
   logic            err_q, err_d;
   logic            rv_q, rv_d;
   logic            pcwe_q, pcwe_d;
   logic            br_taken, br_illegal;
   logic [XLEN-1:0] tgt_calc;

   alu_seq_ctrl_brcond u_brcond (
      .funct3  (f3_q),
      .alu_zero(alu_zero),
      .alu_lt  (alu_lt),
      .alu_ltu (alu_ltu),
      .taken   (br_taken),
      .illegal (br_illegal)
   );

   // JALR targets drop bit0; other targets pass through untouched.
   always_comb begin
      tgt_calc    = alu_res;
      tgt_calc[0] = (op_q == OPC_JALR) ? 1'b0 : alu_res[0];
   end

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      f3_d    = f3_q;
      tgt_d   = tgt_q;
      taken_d = 1'b0;
      err_d   = 1'b0;
      rs_sel  = RS_RS1;
      b_sel   = B_RS2;
      alu_op  = ALU_ADD;
      rd_we   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               op_d = opcode;
               f3_d = funct3;
               case (opcode)
                  OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC: state_d = S_EXEC;
                  OPC_BRANCH:                             state_d = S_CMP;
                  OPC_JAL, OPC_JALR:                      state_d = S_LINK;
                  default: begin
                     state_d = S_DONE;
                     err_d   = 1'b1;
                  end
               endcase
            end
         end
         S_EXEC: begin
            rs_sel  = (op_q == OPC_AUIPC) ? RS_PC : RS_RS1;
            b_sel   = (op_q == OPC_OP) ? B_RS2 : B_IMM;
            alu_op  = ALU_PASS;
            rd_we   = 1'b1;
            state_d = S_DONE;
         end
         S_CMP: begin
            alu_op = ALU_SUB;
            if (br_illegal) begin
               state_d = S_DONE;
               err_d   = 1'b1;
            end else if (br_taken) begin
               state_d = S_TGT;
            end else begin
               state_d = S_DONE;
            end
         end
         S_LINK: begin
            rs_sel  = RS_PC;
            b_sel   = B_FOUR;
            rd_we   = 1'b1;
            state_d = S_TGT;
         end
         S_TGT: begin
            rs_sel  = (op_q == OPC_JALR) ? RS_RS1 : RS_PC;
            b_sel   = B_IMM;
            tgt_d   = tgt_calc;
            taken_d = 1'b1;
`ifdef ALU_SEQ_MISALIGN_EN
            if (tgt_calc[1]) begin
               taken_d = 1'b0;
               err_d   = 1'b1;
            end
`endif
            state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      rv_d   = (state_d == S_DONE);
      pcwe_d = rv_d & taken_d & ~err_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         op_q    <= '0;
         f3_q    <= '0;
         tgt_q   <= '0;
         taken_q <= 1'b0;
         err_q   <= 1'b0;
         rv_q    <= 1'b0;
         pcwe_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         f3_q    <= f3_d;
         tgt_q   <= tgt_d;
         taken_q <= taken_d;
         err_q   <= err_d;
         rv_q    <= rv_d;
         pcwe_q  <= pcwe_d;
      end
   end

   assign req_ready  = (state_q == S_IDLE);
   assign tgt_out    = tgt_q;
   assign pc_we      = pcwe_q;
   assign resp_valid = rv_q;
   assign resp_taken = taken_q;
   assign resp_err   = err_q;

endmodule
